// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the riscv_mem_responder slice.
//   ldr_state_t : boot loader / run / fault state encoding
//   in_range    : address is word aligned and inside the storage window
//   idx_ok      : address is inside the storage window (alignment ignored)
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    LDR_LOAD  = 2'd0,
    LDR_RUN   = 2'd1,
    LDR_FAULT = 2'd2
  } ldr_state_t;

  // Storage spans byte addresses [0, depth*4). Since depth is a power of two,
  // this is the same as requiring all address bits above the word index to be zero.
  function automatic logic idx_ok(input logic [63:0] addr, input int unsigned depth);
    logic [63:0] limit;
    limit = 64'(depth) << 2;
    return addr < limit;
  endfunction

  function automatic logic in_range(input logic [63:0] addr, input int unsigned depth);
    return idx_ok(addr, depth) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/riscv_mem_array.sv
// DEPTH x XLEN word storage.
//   clk                    : write clock
//   we / waddr / wdata     : single synchronous write port
//   fetch_idx / fetch_data : asynchronous read port (instruction side)
//   data_idx / data_data   : asynchronous read port (load side)
// Reads during a write to the same word return the old contents.
// Contents are never cleared by reset.
module riscv_mem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   fetch_idx,
  output logic [XLEN-1:0] fetch_data,
  input  logic [AW-1:0]   data_idx,
  output logic [XLEN-1:0] data_data
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign fetch_data = mem[fetch_idx];
  assign data_data  = mem[data_idx];

endmodule

// File: rtl/riscv_mem_responder.sv
// Unified instruction/data memory with a boot loader front end.
//   clk, rst_n        : clock, asynchronous active-low reset
//   hart_rst          : held high until a program is loaded, and again after a fault
//   pc / instruction  : combinational instruction fetch
//   mem_addr / mem_data / mem_write / mem_read : data port (combinational read, posedge store)
//   ld_valid / ld_ready / ld_data / ld_last    : program load stream
//   fault / fault_addr: sticky fault and the byte address that caused it
//   mmio_data / mmio_strobe : output register written by stores to MMIO_ADDR
// Build option: define RISCV_MEM_MMIO_EN to enable the MMIO output register;
// without it mmio_data/mmio_strobe are 0 and MMIO_ADDR is an ordinary bad address.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 1024,
  parameter logic [XLEN-1:0] MMIO_ADDR = XLEN'(32'hFFFF_FFFC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            hart_rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_write,
  output logic [XLEN-1:0] mem_read,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr,
  output logic [XLEN-1:0] mmio_data,
  output logic            mmio_strobe
);

  localparam int AW = $clog2(DEPTH);

`ifdef RISCV_MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  ldr_state_t      state, state_nx;
  logic [AW:0]     ld_ptr;      // one spare bit: the pointer stops at DEPTH, never wraps
  logic            ld_fire, ld_done;
  logic            running, mmio_hit, st_ok, st_bad, pc_bad;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   pc_idx, d_idx;
  logic [XLEN-1:0] fetch_word, data_word, data_rd;

  assign pc_idx  = pc[AW+1:2];
  assign d_idx   = mem_addr[AW+1:2];

  assign running  = (state == LDR_RUN);
  assign ld_ready = (state == LDR_LOAD);
  assign ld_fire  = ld_valid && ld_ready;
  assign ld_done  = ld_fire && (ld_last || (ld_ptr[AW-1:0] == AW'(DEPTH - 1)));

  assign mmio_hit = MMIO_EN && running && mem_write && (mem_addr == MMIO_ADDR);
  assign st_ok    = running && mem_write && !mmio_hit &&  in_range(64'(mem_addr), DEPTH);
  assign st_bad   = running && mem_write && !mmio_hit && !in_range(64'(mem_addr), DEPTH);
  assign pc_bad   = running && !in_range(64'(pc), DEPTH);

  always_comb begin
    state_nx = state;
    case (state)
      LDR_LOAD:  if (ld_done) state_nx = LDR_RUN;
      LDR_RUN:   if (st_bad || pc_bad) state_nx = LDR_FAULT;
      LDR_FAULT: state_nx = LDR_FAULT;
      default:   state_nx = LDR_FAULT;
    endcase
  end

  // The single write port belongs to the loader while loading, to the hart afterwards.
  always_comb begin
    if (state == LDR_LOAD) begin
      we    = ld_fire;
      waddr = ld_ptr[AW-1:0];
      wdata = ld_data;
    end else begin
      we    = st_ok;
      waddr = d_idx;
      wdata = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LDR_LOAD;
      ld_ptr     <= '0;
      hart_rst   <= 1'b1;
      fault_addr <= '0;
    end else begin
      state    <= state_nx;
      // Follows the next state so the hart leaves reset on the edge that finishes loading.
      hart_rst <= (state_nx != LDR_RUN);
      if (ld_fire) ld_ptr <= ld_ptr + 1'b1;
      // A bad store outranks a bad fetch in the same cycle.
      if (st_bad)      fault_addr <= mem_addr;
      else if (pc_bad) fault_addr <= pc;
    end
  end

  assign fault = (state == LDR_FAULT);

`ifdef RISCV_MEM_MMIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_data   <= '0;
      mmio_strobe <= 1'b0;
    end else begin
      mmio_strobe <= mmio_hit;
      if (mmio_hit) mmio_data <= mem_data;
    end
  end
`else
  assign mmio_data   = '0;
  assign mmio_strobe = 1'b0;
`endif

  riscv_mem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk        (clk),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .fetch_idx  (pc_idx),
    .fetch_data (fetch_word),
    .data_idx   (d_idx),
    .data_data  (data_word)
  );

  // Addresses beyond the storage window read as zero; alignment does not affect reads.
  assign instruction = idx_ok(64'(pc), DEPTH) ? fetch_word : '0;
  assign data_rd     = idx_ok(64'(mem_addr), DEPTH) ? data_word : '0;
  assign mem_read    = (MMIO_EN && (mem_addr == MMIO_ADDR)) ? mmio_data : data_rd;

endmodule
